// File: rtl/branch_ctrl.sv
// Branch prediction / resolution controller: 2-bit counter table, mispredict flush + redirect, squash window.
// Define BRANCH_PREDICT_EN to build the prediction table; otherwise fetch is statically predicted not-taken.
module branch_ctrl #(
  parameter int PHT_IDX_BITS  = 6,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred_taken,
  input  logic        ex_br_en,
  input  logic [31:0] ex_target,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  typedef enum logic {RUN, SQUASH} state_t;

  state_t      state, state_next;
  logic [2:0]  squash_cnt, squash_cnt_next;
  logic        resolve, actual, mispredict, br_update;
  logic [31:0] correct_pc;
  logic        flush_next, redirect_valid_next;
  logic [31:0] redirect_pc_next;
  logic        unused_if_pc;

  assign unused_if_pc = ^if_pc;

  assign resolve    = ex_valid & (ex_is_branch | ex_is_jump) & ~stall & (state == RUN);
  assign actual     = ex_is_jump | (ex_is_branch & ex_br_en);
  assign mispredict = resolve & (actual != ex_pred_taken);
  assign br_update  = resolve & ex_is_branch;
  assign correct_pc = actual ? ex_target : ex_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      squash_cnt <= 3'd0;
    end else begin
      state      <= state_next;
      squash_cnt <= squash_cnt_next;
    end
  end

  // The squash window is counted in non-stalled cycles so a frozen pipe cannot leak wrong-path resolutions.
  always_comb begin
    state_next      = state;
    squash_cnt_next = squash_cnt;
    case (state)
      RUN: begin
        if (mispredict) begin
          state_next      = SQUASH;
          squash_cnt_next = 3'(SQUASH_CYCLES);
        end
      end
      SQUASH: begin
        if (!stall) begin
          if (squash_cnt <= 3'd1) begin
            state_next      = RUN;
            squash_cnt_next = 3'd0;
          end else begin
            squash_cnt_next = squash_cnt - 3'd1;
          end
        end
      end
      default: begin
        state_next      = RUN;
        squash_cnt_next = 3'd0;
      end
    endcase
  end

  always_comb begin
    flush_next          = mispredict;
    redirect_valid_next = mispredict;
    redirect_pc_next    = mispredict ? correct_pc : redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      flush          <= flush_next;
      redirect_valid <= redirect_valid_next;
      redirect_pc    <= redirect_pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
    end else begin
      if (br_update && branch_count != 32'hFFFF_FFFF)
        branch_count <= branch_count + 32'd1;
      if (mispredict && mispredict_count != 32'hFFFF_FFFF)
        mispredict_count <= mispredict_count + 32'd1;
    end
  end

`ifdef BRANCH_PREDICT_EN
  localparam int PHT_ENTRIES = 1 << PHT_IDX_BITS;

  logic [1:0]              pht [PHT_ENTRIES];
  logic [PHT_IDX_BITS-1:0] if_idx, ex_idx;

  assign if_idx = if_pc[PHT_IDX_BITS+1:2];
  assign ex_idx = ex_pc[PHT_IDX_BITS+1:2];

  // Saturating 2-bit counters; entries start weakly not-taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_ENTRIES; i++)
        pht[i] <= 2'b01;
    end else if (br_update) begin
      if (ex_br_en && pht[ex_idx] != 2'b11)
        pht[ex_idx] <= pht[ex_idx] + 2'b01;
      else if (!ex_br_en && pht[ex_idx] != 2'b00)
        pht[ex_idx] <= pht[ex_idx] - 2'b01;
    end
  end

  assign pred_taken = pht[if_idx][1];
`else
  assign pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: expected redirects are queued at issue and checked by a flush monitor.
module tb_branch_ctrl;

`ifdef BRANCH_PREDICT_EN
  localparam logic PRED_EN = 1'b1;
`else
  localparam logic PRED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_pc = 32'd0;
  logic        pred_taken;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic        ex_is_jump = 1'b0;
  logic [31:0] ex_pc = 32'd0;
  logic        ex_pred_taken = 1'b0;
  logic        ex_br_en = 1'b0;
  logic [31:0] ex_target = 32'd0;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  branch_ctrl #(.PHT_IDX_BITS(6), .SQUASH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken), .stall(stall),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .ex_br_en(ex_br_en), .ex_target(ex_target),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
    ex_pred_taken = 1'b0; ex_br_en = 1'b0;
  endtask

  task automatic apply_stimulus(input logic is_br, input logic is_jmp, input logic [31:0] pc,
                                input logic pred, input logic br, input logic [31:0] tgt);
    ex_valid = 1'b1; ex_is_branch = is_br; ex_is_jump = is_jmp; ex_pc = pc;
    ex_pred_taken = pred; ex_br_en = br; ex_target = tgt;
  endtask

  task automatic expect_redirect(input logic [31:0] pc, input logic [31:0] mis);
    exp_q.push_back({pc, mis});
  endtask

  task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
    if_pc = pc;
    #1;
    check_output(name, {31'd0, pred_taken}, {31'd0, exp});
  endtask

  // Every flush cycle must match the oldest queued redirect; a flush with nothing queued is an error.
  always @(negedge clk) begin
    if (flush || redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_flush actual flush=%b redirect_pc=%h expected no flush at %0t",
                 flush, redirect_pc, $time);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check_output("mon_flush", {31'd0, flush}, 32'd1);
        check_output("mon_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check_output("mon_redirect_pc", redirect_pc, e[63:32]);
        check_output("mon_mispredict_count", mispredict_count, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    clear_ex();
    tick(); tick();
    rst_n = 1'b1;
    check_pred("reset_pred_0x100", 32'h100, 1'b0);
    check_output("reset_branch_count", branch_count, 32'd0);
    check_output("reset_mispredict_count", mispredict_count, 32'd0);
    check_output("reset_flush", {31'd0, flush}, 32'd0);
    check_output("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check_output("reset_redirect_pc", redirect_pc, 32'd0);

    // Taken branch predicted not-taken
    apply_stimulus(1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 32'h80);
    expect_redirect(32'h80, 32'd1);
    tick();
    clear_ex();
    check_output("bc_after_first", branch_count, 32'd1);
    check_pred("pred_0x100_trained", 32'h100, PRED_EN);
    tick();
    check_output("flush_one_cycle", {31'd0, flush}, 32'd0);
    tick();

    // Not-taken predicted taken, then resolutions inside the squash window
    apply_stimulus(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h80);
    expect_redirect(32'h104, 32'd2);
    tick();
    apply_stimulus(1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 32'h80);
    tick(); tick();
    clear_ex();
    check_output("squash_branch_count", branch_count, 32'd2);
    check_output("squash_mispredict_count", mispredict_count, 32'd2);
    check_output("squash_no_flush", {31'd0, flush}, 32'd0);
    check_pred("squash_no_update", 32'h100, 1'b0);

    // Saturation at 0x200
    apply_stimulus(1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 32'h240);
    expect_redirect(32'h240, 32'd3);
    tick();
    clear_ex();
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 1'b0, 32'h200, 1'b1, 1'b1, 32'h240);
      tick();
    end
    clear_ex();
    check_pred("pred_0x200_saturated", 32'h200, PRED_EN);
    check_output("bc_after_four", branch_count, 32'd6);
    apply_stimulus(1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h240);
    expect_redirect(32'h204, 32'd4);
    tick();
    clear_ex();
    check_pred("pred_0x200_after_nt", 32'h200, PRED_EN);
    check_output("bc_after_nt", branch_count, 32'd7);
    tick(); tick();

    // Jump held under stall
    apply_stimulus(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h400);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output("stall_no_flush", {31'd0, flush}, 32'd0);
      check_output("stall_mis_count", mispredict_count, 32'd4);
    end
    expect_redirect(32'h400, 32'd5);
    stall = 1'b0;
    tick();
    clear_ex();
    check_output("jump_bc_unchanged", branch_count, 32'd7);
    tick(); tick();

    // Reset during squash
    apply_stimulus(1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 32'h80);
    expect_redirect(32'h80, 32'd6);
    tick();
    clear_ex();
    #3;
    rst_n = 1'b0;
    tick();
    check_output("rst_flush", {31'd0, flush}, 32'd0);
    check_output("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check_output("rst_redirect_pc", redirect_pc, 32'd0);
    check_output("rst_branch_count", branch_count, 32'd0);
    check_output("rst_mispredict_count", mispredict_count, 32'd0);
    check_pred("rst_pred_0x100", 32'h100, 1'b0);
    check_pred("rst_pred_0x200", 32'h200, 1'b0);
    rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b0, 32'h300, 1'b1, 1'b0, 32'h380);
    expect_redirect(32'h304, 32'd1);
    tick();
    clear_ex();
    tick(); tick(); tick();

    check_output("pending_redirects", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution and prediction controller for the pipelined RV32I core. Predicts fetch-stage branches from a table of 2-bit saturating counters, consumes the EX-stage comparator result (`br_en`), and detects mispredictions. On a misprediction it issues a one-cycle pipeline flush and PC redirect, then squashes wrong-path resolutions. Sits between the fetch PC logic, the EX-stage branch comparator, and the pipeline-register flush controls.

## Interface
- `PHT_IDX_BITS`, 6: log2 of prediction-table entries; index is `pc[PHT_IDX_BITS+1:2]`
- `SQUASH_CYCLES`, 2: cycles after a flush during which EX resolutions are ignored (1..7)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `if_pc` in 32: current fetch PC
- `pred_taken` out 1: prediction for `if_pc`, combinational
- `stall` in 1: pipeline freeze; no table update, no flush, no counter change
- `ex_valid` in 1: EX stage holds a real instruction
- `ex_is_branch` in 1: EX instruction is a conditional branch
- `ex_is_jump` in 1: EX instruction is JAL/JALR (always taken)
- `ex_pc` in 32: PC of EX instruction
- `ex_pred_taken` in 1: prediction carried down the pipe with the instruction
- `ex_br_en` in 1: comparator result for the EX branch
- `ex_target` in 32: computed branch/jump target
- `flush` out 1: kill IF/ID/EX pipeline registers
- `redirect_valid` out 1: load `redirect_pc` into the PC
- `redirect_pc` out 32: corrected fetch address
- `branch_count` out 32: resolved conditional branches
- `mispredict_count` out 32: mispredicted branches and jumps

## Operation
- Resolve event R = `ex_valid & (ex_is_branch | ex_is_jump) & !stall & state==RUN`.
- actual = `ex_is_jump | (ex_is_branch & ex_br_en)`; mispredict M = R & (actual != `ex_pred_taken`).
- Correct PC = actual ? `ex_target` : `ex_pc + 32'd4` (mod 2^32).
- States: RUN, SQUASH.
  - RUN, M: register flush=1, redirect_valid=1, redirect_pc; load squash counter with `SQUASH_CYCLES`; go SQUASH.
  - SQUASH: counter decrements each non-stalled cycle; return to RUN when it reaches 0. EX resolutions ignored (no update, no flush, no count). Stall holds the counter.
- Table update on R & `ex_is_branch`: entry at `ex_pc` index increments if `ex_br_en`, else decrements, saturating at 2'b11 / 2'b00. Jumps never update the table.
- `pred_taken` = MSB of entry at `if_pc` index.
- `branch_count` increments on R & `ex_is_branch`; `mispredict_count` increments on M. Both saturate at 32'hFFFF_FFFF.

## Timing
- Reset (`rst_n`=0 at edge): state RUN, squash counter 0, all table entries 2'b01, `flush`=0, `redirect_valid`=0, `redirect_pc`=0, both counters 0. Reset mid-squash or mid-flush returns to RUN next cycle.
- `pred_taken`: zero latency, combinational from table registers.
- `flush`/`redirect_valid`: asserted exactly one cycle, the cycle after M is sampled; deasserted regardless of `stall` in that cycle.
- Table write lands at the edge after R; a same-cycle lookup of the written index returns the pre-update value.
- `stall`=1 with M conditions present: no action; the event is re-evaluated when `stall` drops.
- Back-to-back mispredicts are impossible: the second falls in SQUASH and is dropped.

## Configuration
- `BRANCH_PREDICT_EN` defined: behaviour above.
- Not defined: no table is instantiated; `pred_taken` is constant 0 (static not-taken), table updates are removed, mispredict detection, flush, squash, and counters are unchanged.

## Test plan
- After reset, `if_pc`=0x100 -> `pred_taken`=0; `branch_count`=0, `flush`=0.
- Branch at `ex_pc`=0x100, `ex_pred_taken`=0, `ex_br_en`=1, `ex_target`=0x80 -> next cycle `flush`=1, `redirect_pc`=0x80 for one cycle; `mispredict_count`=1; `pred_taken` for 0x100 becomes 1.
- Same branch not taken, predicted taken -> `redirect_pc`=0x104; a resolve event presented during the following 2 cycles produces no flush, and counts stay fixed.
- Taken branch at 0x200 resolved 4 times, correctly predicted from the 2nd on -> counter saturates at 2'b11, no further flush; then 1 not-taken -> `pred_taken` still 1.
- JAL at 0x300, `ex_pred_taken`=0, target 0x400, with `stall`=1 for 3 cycles -> no flush until `stall` drops, then `redirect_pc`=0x400; `branch_count` unchanged.
- Mispredict, then `rst_n`=0 during SQUASH -> next cycle state RUN, outputs and counters 0, and all table entries read back as weakly not-taken.
